// File: rtl/aq_djpeg_dequant_pkg.sv
// aq_djpeg_dequant_pkg
// Shared constants and the saturation helper for the JPEG dequantiser.
// No ports; imported by aq_djpeg_dequant and aq_djpeg_dequant_ram.
package aq_djpeg_dequant_pkg;

    localparam int QT_NUM   = 4;                 // quant tables Tq 0..3
    localparam int QT_WIDTH = 8;                 // 8-bit precision entries only
    localparam int TQ_W     = 2;                 // table select width
    localparam int IDX_W    = 6;                 // zigzag index width
    localparam int QT_AW    = TQ_W + IDX_W;      // quant RAM address width
    localparam int QT_DEPTH = QT_NUM * 64;
    localparam int COLOR_W  = 3;
    localparam int COEF_W   = 16;
    localparam int PROD_W   = 24;

    localparam logic signed [PROD_W-1:0] SAT_MAX = 24'sd32767;
    localparam logic signed [PROD_W-1:0] SAT_MIN = -24'sd32768;

    // Clamp a full-width product into the signed 16-bit coefficient range.
    function automatic logic [COEF_W-1:0] sat_coef(input logic signed [PROD_W-1:0] p);
        if (p > SAT_MAX)
            sat_coef = SAT_MAX[COEF_W-1:0];
        else if (p < SAT_MIN)
            sat_coef = SAT_MIN[COEF_W-1:0];
        else
            sat_coef = p[COEF_W-1:0];
    endfunction

endpackage

// File: rtl/aq_djpeg_dequant_ram.sv
// aq_djpeg_dequant_ram
// Quant table storage: 256x8 simple dual-port RAM, one write and one
// synchronous read port. A read of the entry being written in the same cycle
// returns the old contents. Contents are never reset.
// Ports:
//   clk    in   clock
//   we     in   write strobe
//   waddr  in   write address {Tq, zigzag index}
//   wdata  in   quant value
//   raddr  in   read address {Tq, zigzag index}
//   rdata  out  registered read data
module aq_djpeg_dequant_ram
    import aq_djpeg_dequant_pkg::*;
(
    input  logic                clk,
    input  logic                we,
    input  logic [QT_AW-1:0]    waddr,
    input  logic [QT_WIDTH-1:0] wdata,
    input  logic [QT_AW-1:0]    raddr,
    output logic [QT_WIDTH-1:0] rdata
);

    logic [QT_WIDTH-1:0] mem [QT_DEPTH];

    // Read and write share one block so the read samples the pre-write value.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/aq_djpeg_dequant.sv
// aq_djpeg_dequant
// Dequantiser between the Huffman decoder and the zigzag reorder buffer.
// Each coefficient is multiplied by its DQT entry, saturated to 16 bits and
// forwarded with its index/colour/end framing after a fixed 2-cycle latency.
// Ports:
//   clk, rst                    clock; synchronous active-low reset
//   DataInit                    frame init: flush pipeline, clear component map
//   QtWrEnable/Table/Address/Data   DQT entry write
//   CompWrEnable/Color/Table    component -> quant table mapping write
//   HufEnable/Address/Color/Data/EndEnable   coefficient stream in
//   HufIdle                     upstream may start a new block
//   DownIdle                    zigzag buffer can accept a new block
//   DataOutEnable/Address/Color, DataOut, EndEnable   coefficient stream out
module aq_djpeg_dequant
    import aq_djpeg_dequant_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               DataInit,
    input  logic               QtWrEnable,
    input  logic [TQ_W-1:0]    QtWrTable,
    input  logic [IDX_W-1:0]   QtWrAddress,
    input  logic [QT_WIDTH-1:0] QtWrData,
    input  logic               CompWrEnable,
    input  logic [1:0]         CompWrColor,
    input  logic [TQ_W-1:0]    CompWrTable,
    input  logic               HufEnable,
    input  logic [IDX_W-1:0]   HufAddress,
    input  logic [COLOR_W-1:0] HufColor,
    input  logic [COEF_W-1:0]  HufData,
    input  logic               HufEndEnable,
    output logic               HufIdle,
    input  logic               DownIdle,
    output logic               DataOutEnable,
    output logic [IDX_W-1:0]   DataOutAddress,
    output logic [COLOR_W-1:0] DataOutColor,
    output logic [COEF_W-1:0]  DataOut,
    output logic               EndEnable
);

    logic [TQ_W-1:0]    comp_table [QT_NUM];
    logic [QT_WIDTH-1:0] q_s1;

    logic               vld_s1;
    logic               end_s1;
    logic [IDX_W-1:0]   addr_s1;
    logic [COLOR_W-1:0] color_s1;
    logic [COEF_W-1:0]  data_s1;

    logic signed [PROD_W-1:0] data_ext;
    logic signed [PROD_W-1:0] q_ext;
    logic signed [PROD_W-1:0] prod;

    always_ff @(posedge clk) begin
        if (!rst || DataInit) begin
            for (int i = 0; i < QT_NUM; i++)
                comp_table[i] <= '0;
        end else if (CompWrEnable) begin
            comp_table[CompWrColor] <= CompWrTable;
        end
    end

    // Only the low two colour bits select a component slot.
    aq_djpeg_dequant_ram u_ram (
        .clk   (clk),
        .we    (QtWrEnable),
        .waddr ({QtWrTable, QtWrAddress}),
        .wdata (QtWrData),
        .raddr ({comp_table[HufColor[1:0]], HufAddress}),
        .rdata (q_s1)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_s1   <= 1'b0;
            end_s1   <= 1'b0;
            addr_s1  <= '0;
            color_s1 <= '0;
            data_s1  <= '0;
        end else begin
            vld_s1   <= HufEnable & ~DataInit;
            end_s1   <= HufEndEnable & ~DataInit;
            addr_s1  <= HufAddress;
            color_s1 <= HufColor;
            data_s1  <= HufData;
        end
    end

    // Coefficient is signed, quant entry unsigned; the 24-bit signed product
    // covers the full range (32768*255 < 2^23).
    always_comb begin
        data_ext = {{(PROD_W-COEF_W){data_s1[COEF_W-1]}}, data_s1};
        q_ext    = {{(PROD_W-QT_WIDTH){1'b0}}, q_s1};
        prod     = data_ext * q_ext;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            DataOutEnable  <= 1'b0;
            EndEnable      <= 1'b0;
            DataOutAddress <= '0;
            DataOutColor   <= '0;
            DataOut        <= '0;
        end else begin
            DataOutEnable  <= vld_s1 & ~DataInit;
            EndEnable      <= end_s1 & ~DataInit;
            DataOutAddress <= addr_s1;
            DataOutColor   <= color_s1;
            DataOut        <= sat_coef(prod);
        end
    end

    // An end still in flight occupies the downstream buffer, so hold off the
    // next block until it has been delivered.
    assign HufIdle = DownIdle & ~end_s1 & ~EndEnable;

endmodule

// File: tb/tb_aq_djpeg_dequant.sv
module tb_aq_djpeg_dequant;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        DataInit = 1'b0;
    logic        QtWrEnable = 1'b0;
    logic [1:0]  QtWrTable = '0;
    logic [5:0]  QtWrAddress = '0;
    logic [7:0]  QtWrData = '0;
    logic        CompWrEnable = 1'b0;
    logic [1:0]  CompWrColor = '0;
    logic [1:0]  CompWrTable = '0;
    logic        HufEnable = 1'b0;
    logic [5:0]  HufAddress = '0;
    logic [2:0]  HufColor = '0;
    logic [15:0] HufData = '0;
    logic        HufEndEnable = 1'b0;
    logic        HufIdle;
    logic        DownIdle = 1'b1;
    logic        DataOutEnable;
    logic [5:0]  DataOutAddress;
    logic [2:0]  DataOutColor;
    logic [15:0] DataOut;
    logic        EndEnable;

    aq_djpeg_dequant dut (
        .clk(clk), .rst(rst), .DataInit(DataInit),
        .QtWrEnable(QtWrEnable), .QtWrTable(QtWrTable), .QtWrAddress(QtWrAddress), .QtWrData(QtWrData),
        .CompWrEnable(CompWrEnable), .CompWrColor(CompWrColor), .CompWrTable(CompWrTable),
        .HufEnable(HufEnable), .HufAddress(HufAddress), .HufColor(HufColor), .HufData(HufData),
        .HufEndEnable(HufEndEnable), .HufIdle(HufIdle), .DownIdle(DownIdle),
        .DataOutEnable(DataOutEnable), .DataOutAddress(DataOutAddress), .DataOutColor(DataOutColor),
        .DataOut(DataOut), .EndEnable(EndEnable)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Reference state: quant tables and component map as firmware wrote them.
    int qt [4][64];
    int comp [4];

    typedef struct {
        int due;
        bit v;
        bit e;
        int addr;
        int color;
        int data;
    } exp_t;
    exp_t pend [$];

    function automatic int sat(int p);
        if (p > 32767) return 32767;
        if (p < -32768) return -32768;
        return p;
    endfunction

    task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Advance one clock, updating the reference model with what the current
    // inputs mean, then check the outputs against what is due this cycle.
    task automatic tick();
        bit was_rst;
        bit ev, ee, eidle;
        int ea, ec, ed;
        was_rst = !rst;
        if (!rst || DataInit) begin
            pend.delete();
            for (int c = 0; c < 4; c++) comp[c] = 0;
        end else begin
            if (HufEnable || HufEndEnable) begin
                exp_t e;
                e.due   = cyc + 2;
                e.v     = HufEnable;
                e.e     = HufEndEnable;
                e.addr  = HufAddress;
                e.color = HufColor;
                e.data  = HufEnable ?
                          sat(int'($signed(HufData)) * qt[comp[HufColor[1:0]]][HufAddress]) : 0;
                pend.push_back(e);
            end
            if (CompWrEnable) comp[CompWrColor] = CompWrTable;
        end
        if (QtWrEnable) qt[QtWrTable][QtWrAddress] = QtWrData;

        @(posedge clk);
        cyc++;
        #1;

        ev = 0; ee = 0; ea = 0; ec = 0; ed = 0; eidle = DownIdle;
        foreach (pend[i]) begin
            if (pend[i].due == cyc) begin
                ev = pend[i].v; ee = pend[i].e;
                ea = pend[i].addr; ec = pend[i].color; ed = pend[i].data;
            end
            if (pend[i].e && pend[i].due <= cyc + 1) eidle = 0;
        end
        chk("out_enable", DataOutEnable, ev);
        chk("end_enable", EndEnable, ee);
        if (ev) begin
            chk("data_out", $signed(DataOut), ed);
            chk("out_address", DataOutAddress, ea);
            chk("out_color", DataOutColor, ec);
        end
        if (was_rst) begin
            chk("rst_data", DataOut, 0);
            chk("rst_address", DataOutAddress, 0);
            chk("rst_color", DataOutColor, 0);
        end
        chk("huf_idle", HufIdle, eidle);
        while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
    endtask

    task automatic clear_inputs();
        DataInit = 0; QtWrEnable = 0; CompWrEnable = 0; HufEnable = 0; HufEndEnable = 0;
    endtask

    task automatic qt_wr(int t, int a, int d);
        QtWrEnable = 1; QtWrTable = 2'(t); QtWrAddress = 6'(a); QtWrData = 8'(d);
        tick();
        QtWrEnable = 0;
    endtask

    task automatic comp_wr(int c, int t);
        CompWrEnable = 1; CompWrColor = 2'(c); CompWrTable = 2'(t);
        tick();
        CompWrEnable = 0;
    endtask

    task automatic coef(int a, int c, int d);
        HufEnable = 1; HufAddress = 6'(a); HufColor = 3'(c); HufData = 16'(d);
        tick();
        HufEnable = 0;
    endtask

    task automatic end_pulse();
        HufEndEnable = 1;
        tick();
        HufEndEnable = 0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int t = 0; t < 4; t++) begin
            comp[t] = 0;
            for (int a = 0; a < 64; a++) qt[t][a] = 0;
        end

        // Reset state
        rst = 0;
        idle(2);
        rst = 1;
        idle(1);

        // Tq0 all 16, colour0 -> Tq0, a block of value 3
        for (int a = 0; a < 64; a++) qt_wr(0, a, 16);
        comp_wr(0, 0);
        for (int a = 0; a < 64; a++) coef(a, 0, 3);
        end_pulse();
        idle(3);

        // Saturation through Tq1[5]=255
        qt_wr(1, 5, 255);
        comp_wr(1, 1);
        coef(5, 1, 32767);
        coef(5, 1, -32768);
        coef(5, 1, -100);
        idle(3);

        // Per-colour table selection; colour bit 2 does not affect selection
        qt_wr(2, 0, 10);
        qt_wr(3, 0, 20);
        comp_wr(0, 2);
        comp_wr(1, 3);
        comp_wr(2, 2);
        coef(0, 0, 7);
        coef(0, 1, 7);
        coef(0, 2, 7);
        coef(0, 5, 7);
        idle(3);

        // Idle handshake with an end in flight, then DownIdle low
        DownIdle = 1;
        end_pulse();
        idle(3);
        DownIdle = 0;
        #1;
        chk("huf_idle_downidle", HufIdle, 0);
        idle(1);
        DownIdle = 1;
        idle(1);

        // DataInit flushes a coefficient and an end in flight, clears the map
        coef(1, 1, 5);
        end_pulse();
        DataInit = 1;
        tick();
        DataInit = 0;
        idle(3);
        coef(0, 1, 2);          // colour1 now maps to Tq0 -> 2*16
        coef(5, 0, 3);          // Tq1 untouched by the map reset; Tq0[5]=16
        idle(3);

        // Write/read collision returns the old quant value
        comp_wr(0, 0);
        qt_wr(0, 3, 4);
        QtWrEnable = 1; QtWrTable = 0; QtWrAddress = 3; QtWrData = 9;
        coef(3, 0, 2);
        QtWrEnable = 0;
        coef(3, 0, 2);
        coef(7, 0, 1);
        rst = 0;
        tick();
        rst = 1;
        idle(2);

        // Randomized traffic against the reference model
        for (int t = 0; t < 4; t++)
            for (int a = 0; a < 64; a++)
                qt_wr(t, a, ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 255));
        for (int c = 0; c < 4; c++) comp_wr(c, $urandom_range(0, 3));
        for (int i = 0; i < 400; i++) begin
            HufEnable    = ($urandom_range(0, 9) < 7);
            HufAddress   = 6'($urandom);
            HufColor     = 3'($urandom);
            HufData      = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 1) ? 16'h7fff : 16'h8000)
                                                        : 16'($urandom);
            HufEndEnable = ($urandom_range(0, 9) == 0);
            DownIdle     = ($urandom_range(0, 3) != 0);
            QtWrEnable   = ($urandom_range(0, 15) == 0);
            QtWrTable    = 2'($urandom);
            QtWrAddress  = 6'($urandom);
            QtWrData     = 8'($urandom);
            CompWrEnable = ($urandom_range(0, 31) == 0);
            CompWrColor  = 2'($urandom);
            CompWrTable  = 2'($urandom);
            DataInit     = ($urandom_range(0, 49) == 0);
            tick();
        end
        clear_inputs();
        DownIdle = 1;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
